rsa_half_power_mod: RTL

Computes 2^-power mod modulus for an odd modulus by repeated modular halving, one halving per clock. It is the inverse-direction companion of the two-power-mod block, which computes 2^power mod N. Montgomery-domain conversion logic uses it to produce R^-1 mod N, and the RSA datapath uses it to strip Montgomery scaling factors. It sits behind a valid/ready input port and drives a valid/ready output port, like every other RSA_pkg stage.

---
 rtl/rsa_half_power_mod_pkg.sv | 18 +
 rtl/rsa_half_mod_step.sv | 20 ++
 rtl/rsa_half_power_mod.sv | 101 ++++++++++
 3 files changed

// File: rtl/rsa_half_power_mod_pkg.sv
// Shared RSA datapath types for the modular half-power block.
// Holds the modulus width, the scalar and key types, and the request/response
// payloads of the 2^-power mod N stage.
package rsa_half_power_mod_pkg;

    localparam int MOD_WIDTH = 256;

    typedef logic [31:0]          IntType;
    typedef logic [MOD_WIDTH-1:0] KeyType;

    typedef struct packed {
        IntType power;
        KeyType modulus;
    } RSAHalfPowerModIn;

    typedef KeyType RSAHalfPowerModOut;

endpackage

// File: rtl/rsa_half_mod_step.sv
// One modular halving step: r_out = r_in / 2 mod n for odd n.
// An odd r_in first has n added so the sum is even and the shift is exact.
// The sum is formed one bit wider than the modulus, so it cannot overflow.
module rsa_half_mod_step
    import rsa_half_power_mod_pkg::*;
(
    input  KeyType r_in,
    input  KeyType n,
    output KeyType r_out
);

    logic [MOD_WIDTH:0] sum;

    // Halve r, first adding n when r is odd so the shift is exact.
    always_comb begin
        sum   = {1'b0, r_in} + {1'b0, n};
        r_out = r_in[0] ? KeyType'(sum >> 1) : (r_in >> 1);
    end

endmodule

// File: rtl/rsa_half_power_mod.sv
// Computes 2^-power mod modulus for an odd modulus, one halving per clock.
// Request/response are valid/ready handshakes; only one request is in flight
// at a time and nothing is queued. With r < N maintained by every halving,
// the result needs no final correction.
module rsa_half_power_mod
    import rsa_half_power_mod_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              i_ready,
    input  RSAHalfPowerModIn  i_in,
    output logic              o_valid,
    input  logic              o_ready,
    output RSAHalfPowerModOut o_out
);

    typedef enum logic [1:0] {
        IDLE,
        LOOP,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    IntType power_q;
    KeyType mod_q;
    KeyType r;
    KeyType r_step;
    IntType cnt;
    logic   accept;
    logic   last_step;

    rsa_half_mod_step u_step (
        .r_in  (r),
        .n     (mod_q),
        .r_out (r_step)
    );

    assign accept = i_valid && i_ready;
    // cnt never exceeds power-1 while in LOOP, so cnt+1 cannot wrap.
    assign last_step = ((cnt + 32'd1) == power_q);

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; result is only presented in DONE.
    always_comb begin
        state_nxt = state;
        i_ready   = 1'b0;
        o_valid   = 1'b0;
        o_out     = '0;
        case (state)
            IDLE: begin
                i_ready = 1'b1;
                if (i_valid) begin
                    state_nxt = (i_in.power == 32'd0) ? DONE : LOOP;
                end
            end
            LOOP: begin
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                o_valid = 1'b1;
                o_out   = r;
                if (o_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch, running residue and halving counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            power_q <= '0;
            mod_q   <= '0;
            r       <= KeyType'(1);
            cnt     <= '0;
        end else if (accept) begin
            power_q <= i_in.power;
            mod_q   <= i_in.modulus;
            r       <= KeyType'(1);
            cnt     <= '0;
        end else if (state == LOOP) begin
            r   <= r_step;
            cnt <= cnt + 32'd1;
        end
    end

endmodule
